uart_receiver: RTL

Serial-to-parallel UART receive stage that sits directly downstream of the baud controller. It consumes the 16x-oversampling strobe `sample_ENABLE` and the raw serial line `RxD`. It recovers 8N1-plus-parity frames (start, 8 data LSB first, parity, stop) and presents each byte with a one-cycle valid pulse and sticky error flags.

---
 rtl/uart_receiver.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// UART receive stage: 16x-oversampled start/8 data/parity/stop frame recovery with
// mid-bit majority voting, one-cycle valid pulse and sticky per-frame error flags.
module uart_receiver #(
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_ENABLE,
    input  logic       Rx_EN,
    input  logic       RxD,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_PERROR,
    output logic       Rx_FERROR
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e      state_q, state_d;
    logic        rx_meta_q, rxs_q;
    logic [3:0]  tick_q, tick_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic        s7_q, s7_d;
    logic        s8_q, s8_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        perr_q, perr_d;
    logic        ferr_q, ferr_d;

    logic [3:0]  tick_nxt;
    logic        maj;
    logic        frame_perr;

    assign tick_nxt   = tick_q + 4'd1;
    // Vote of the tick-7 and tick-8 samples with the live tick-9 sample.
    assign maj        = (s7_q & s8_q) | (s7_q & rxs_q) | (s8_q & rxs_q);
    assign frame_perr = (^shift_q) ^ par_q ^ PARITY_ODD;

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        s7_d    = s7_q;
        s8_d    = s8_q;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;

        if (!Rx_EN) begin
            state_d = StIdle;
            tick_d  = 4'd0;
            idx_d   = 3'd0;
        end else if (sample_ENABLE) begin
            if (state_q != StIdle) begin
                tick_d = tick_nxt;
                if (tick_nxt == 4'd7) s7_d = rxs_q;
                if (tick_nxt == 4'd8) s8_d = rxs_q;
            end

            case (state_q)
                StIdle: begin
                    // The detecting strobe itself is tick 0 of the start bit.
                    if (!rxs_q) begin
                        state_d = StStart;
                        tick_d  = 4'd0;
                    end
                end
                StStart: begin
                    if (tick_nxt == 4'd9 && maj) begin
                        state_d = StIdle;
                        tick_d  = 4'd0;
                    end else if (tick_nxt == 4'd15) begin
                        state_d = StData;
                        idx_d   = 3'd0;
                    end
                end
                StData: begin
                    if (tick_nxt == 4'd9) shift_d[idx_q] = maj;
                    if (tick_nxt == 4'd15) begin
                        idx_d = idx_q + 3'd1;
                        if (idx_q == 3'd7) state_d = StParity;
                    end
                end
                StParity: begin
                    if (tick_nxt == 4'd9) par_d = maj;
                    if (tick_nxt == 4'd15) state_d = StStop;
                end
                StStop: begin
                    // Finish mid stop bit so the next start edge is caught promptly.
                    if (tick_nxt == 4'd9) begin
                        perr_d  = frame_perr;
                        ferr_d  = ~maj;
                        if (!frame_perr && maj) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end
                        state_d = StIdle;
                        tick_d  = 4'd0;
                    end
                end
                default: begin
                    state_d = StIdle;
                    tick_d  = 4'd0;
                    idx_d   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            state_q   <= StIdle;
            tick_q    <= 4'd0;
            idx_q     <= 3'd0;
            shift_q   <= 8'h00;
            par_q     <= 1'b0;
            s7_q      <= 1'b1;
            s8_q      <= 1'b1;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= RxD;
            rxs_q     <= rx_meta_q;
            state_q   <= state_d;
            tick_q    <= tick_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            s7_q      <= s7_d;
            s8_q      <= s8_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    assign Rx_DATA   = data_q;
    assign Rx_VALID  = valid_q;
    assign Rx_PERROR = perr_q;
    assign Rx_FERROR = ferr_q;

endmodule
